// File: rtl/capture_window_controller.sv
// capture_window_controller: gates raw sensor framing to a crop window for one frame per start request.
// Optional watchdog on frame-start waits is enabled by defining CAPTURE_TIMEOUT_EN.
module capture_window_controller #(
  parameter int          MAX_DIM        = 2048,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
  input  logic                       clock_in,
  input  logic                       reset_in,
  input  logic                       start_capture_in,
  input  logic                       abort_in,
  input  logic                       frame_valid_in,
  input  logic                       line_valid_in,
  input  logic [$clog2(MAX_DIM)-1:0] x_offset_in,
  input  logic [$clog2(MAX_DIM)-1:0] y_offset_in,
  input  logic [$clog2(MAX_DIM)-1:0] width_in,
  input  logic [$clog2(MAX_DIM)-1:0] height_in,
  output logic                       frame_valid_out,
  output logic                       line_valid_out,
  output logic                       busy_out,
  output logic                       capture_done_out,
  output logic                       short_frame_out,
  output logic                       timeout_out
);
  localparam int W = $clog2(MAX_DIM);
  localparam logic [2:0] IDLE             = 3'd0;
  localparam logic [2:0] WAIT_FRAME_END   = 3'd1;
  localparam logic [2:0] WAIT_FRAME_START = 3'd2;
  localparam logic [2:0] CAPTURE          = 3'd3;
  localparam logic [2:0] DONE             = 3'd4;
  logic [2:0]   state;
  logic [W-1:0] x_off, y_off, wid, hgt, x_count, y_count;
  logic [W:0]   x_end, y_end;
  logic         lv_d, live, in_x, in_y, waiting, wd_hit;
  assign x_end    = {1'b0, x_off} + {1'b0, wid};
  assign y_end    = {1'b0, y_off} + {1'b0, hgt};
  assign in_x     = x_count >= x_off && {1'b0, x_count} < x_end;
  assign in_y     = y_count >= y_off && {1'b0, y_count} < y_end;
  assign waiting  = state == WAIT_FRAME_END || state == WAIT_FRAME_START;
  assign busy_out = state != IDLE;
  // The first active cycle seen in WAIT_FRAME_START already counts as captured, keeping latency at one cycle.
  assign live = !abort_in && frame_valid_in && (state == CAPTURE || state == WAIT_FRAME_START);
`ifdef CAPTURE_TIMEOUT_EN
  logic [23:0] wd;
  assign wd_hit = (state == WAIT_FRAME_END || (state == WAIT_FRAME_START && !frame_valid_in))
                  && wd == TIMEOUT_CYCLES - 24'd1;
  always_ff @(posedge clock_in) wd <= (reset_in || !waiting) ? 24'd0 : wd + 24'd1;
`else
  assign wd_hit = 1'b0;
`endif
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state            <= IDLE;
      x_off            <= '0;
      y_off            <= '0;
      wid              <= '0;
      hgt              <= '0;
      x_count          <= '0;
      y_count          <= '0;
      lv_d             <= 1'b0;
      frame_valid_out  <= 1'b0;
      line_valid_out   <= 1'b0;
      capture_done_out <= 1'b0;
      short_frame_out  <= 1'b0;
      timeout_out      <= 1'b0;
    end else begin
      lv_d             <= live && line_valid_in;
      x_count          <= (live && line_valid_in) ? x_count + 1'b1 : '0;
      y_count          <= !live ? '0 : (lv_d && !line_valid_in) ? y_count + 1'b1 : y_count;
      frame_valid_out  <= live;
      line_valid_out   <= live && line_valid_in && in_x && in_y;
      capture_done_out <= !abort_in && state == CAPTURE && !frame_valid_in;
      timeout_out      <= !abort_in && wd_hit;
      if (abort_in)
        state <= IDLE;
      else if (state == IDLE) begin
        if (start_capture_in) begin
          x_off           <= x_offset_in;
          y_off           <= y_offset_in;
          wid             <= width_in;
          hgt             <= height_in;
          short_frame_out <= 1'b0;
          state           <= frame_valid_in ? WAIT_FRAME_END : WAIT_FRAME_START;
        end
      end else if (state == WAIT_FRAME_END)
        state <= wd_hit ? IDLE : frame_valid_in ? WAIT_FRAME_END : WAIT_FRAME_START;
      else if (state == WAIT_FRAME_START)
        state <= frame_valid_in ? CAPTURE : wd_hit ? IDLE : WAIT_FRAME_START;
      else if (state == CAPTURE) begin
        if (!frame_valid_in) begin
          state <= DONE;
          if ({1'b0, y_count} < y_end) short_frame_out <= 1'b1;
        end
      end else
        state <= IDLE;
    end
  end
endmodule
